sfsm_top: RTL and testbench
===========================

Name: sfsm_top

Overview:
- Table-driven finite state machine. The transition and output table lives in an external SPI serial memory (standard 0x03 READ command).
- Each step:
  - Forms a memory address from the current state and the 5 general-purpose inputs.
  - Reads a 16-bit word serially from the memory.
  - Loads the next state and the 6 general-purpose outputs from that word.
- Sits at chip top behind the 8-in/8-out packed IO wrapper.
- No SCK pin: the board clocks the memory with the inverted chip clock.

Parameters:
- STATE_W, 4, state register width (address = {zero pad, state, gpi}).
- CMD_READ, 8'h03, serial command byte sent at frame start.
- ADDR_BITS, 16, address field length sent after the command.

Ports:
- io_in input 8: [0]=clk (single clock, all logic on rising edge), [1]=rst (asynchronous, active-high), [2]=din (serial data from memory), [7:3]=gpi[4:0].
- io_out output 8: [0]=cs (memory chip select, active-low), [1]=dout (serial data to memory), [7:2]=gpo[5:0].

Behaviour:
- Reset (asynchronous, active-high): cs=1, dout=0, gpo=0, state=0, frame counter cnt=0. All take effect immediately, even mid-frame; the frame is aborted. The first frame starts on the first rising edge after rst deasserts.
- Frame = 41 clk cycles, cnt 0..40, all signals registered:
  - cnt 0: gap cycle; cs=1, dout=0. On the edge leaving cnt 0, latch addr = {(16-STATE_W-5) zeros, state, gpi}.
  - cnt 1..8: cs=0; dout = CMD_READ, MSB first.
  - cnt 9..24: cs=0; dout = addr[15:0], MSB first.
  - cnt 25..40: cs=0, dout=0. din is sampled at the rising edge that ends each cycle and shifted into a 16-bit word, MSB first.
  - Edge ending cnt 40: state ← word[15:12], gpo ← word[5:0], cnt ← 0 (cs returns high).
- Data word fields: [15:12] next state; [11] halt (see optional feature); [10:6] reserved, ignored; [5:0] gpo.
- Output timing:
  - gpo changes only at frame end, once per 41 cycles, and is glitch-free.
  - Latency from gpi sample to gpo update: 40 cycles.
- gpi changes after the cnt 0 latch edge do not affect the current frame.
- din is ignored outside cnt 25..40.
- No handshake or error detection; whatever the memory returns is used.
- State wrap: any 4-bit value is legal; state 15 is not special.

Optional Feature:
- Macro SFSM_HALT_EN.
- Defined: if the fetched word[11]=1, state and gpo still load at frame end, then the block enters HALT:
  - cs stays 1, dout=0, no further frames.
  - Outputs are frozen until reset.
- Undefined: word[11] is ignored and frames run continuously.

Decomposition:
- Package sfsm_pkg holds:
  - constants CMD_READ, ADDR_BITS, DATA_BITS=16, FRAME_LEN=41;
  - phase boundaries (GAP=0, CMD_END=8, ADDR_END=24, DATA_END=40);
  - field positions NEXT_MSB=15, NEXT_LSB=12, HALT_BIT=11, GPO_MSB=5;
  - phase enum {GAP, CMD, ADDR, DATA, HALT}.
- One sub-module, sfsm_spi_frame:
  - owns the counter, the command/address shift register and the data shift register;
  - presents the word plus a one-cycle done pulse.
- Top keeps the state and gpo registers plus the IO packing.

Test Plan:
- Reset: assert rst mid-frame at cnt 15 → cs=1, dout=0, gpo=0 immediately. Release → gap at cnt 0, cs falls one cycle later.
- Frame format: state=0, gpi=5'b10110 → dout over cnt 1..24 = 0x03 then 0x0016, MSB first. cs low exactly cnt 1..40, high at cnt 0.
- Data load: memory model returns 0x5015 → after the cnt 40 edge, gpo=6'h15 and state=5. The next frame with gpi=5'b10110 sends address 0x00B6.
- Chained transitions, memory model programmed as a table:
  - (0, gpi=0) → 0x1001;
  - (1, gpi=0) → 0x203F;
  - expected: gpo=0x01 then 0x3F on successive frames, 41 cycles apart, state 2 after frame 2.
- gpi timing: change gpi at cnt 5 → current frame address unchanged; the new value is used in the next frame.
- Halt (SFSM_HALT_EN): returned word 0x3812 → gpo=0x12, state 3, then cs held 1 for 200 cycles. Without the macro, the next frame starts normally at cnt 0.

Source files
------------

// File: rtl/sfsm_pkg.sv
// sfsm_pkg: shared constants, data-word field map and frame phases
// for the table-driven serial-memory state machine.
package sfsm_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         ADDR_BITS = 16;
    localparam int         DATA_BITS = 16;
    localparam int         FRAME_LEN = 41;

    localparam int GAP      = 0;
    localparam int CMD_END  = 8;
    localparam int ADDR_END = 24;
    localparam int DATA_END = 40;

    localparam int NEXT_MSB = 15;
    localparam int NEXT_LSB = 12;
    localparam int HALT_BIT = 11;
    localparam int GPO_MSB  = 5;

    typedef enum logic [2:0] {
        PH_GAP,
        PH_CMD,
        PH_ADDR,
        PH_DATA,
        PH_HALT
    } phase_e;

endpackage

// File: rtl/sfsm_spi_frame.sv
// sfsm_spi_frame: runs one READ frame (gap, command, address, data) and
// presents the fetched word with a done pulse. SFSM_HALT_EN adds HALT.
module sfsm_spi_frame
    import sfsm_pkg::*;
#(
    parameter logic [7:0] P_CMD  = CMD_READ,
    parameter int         P_ADDR = ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_din,
    input  logic [P_ADDR-1:0]    i_addr,
    output logic                 o_cs_n,
    output logic                 o_dout,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_done
);

    localparam int SH_W  = 8 + P_ADDR;
    localparam int A_END = CMD_END + P_ADDR;
    localparam int D_END = A_END + DATA_BITS;
    localparam int CW    = $clog2(D_END + 1);

    localparam logic [CW-1:0] C_CMD_END = CW'(CMD_END);
    localparam logic [CW-1:0] C_A_END   = CW'(A_END);
    localparam logic [CW-1:0] C_D_END   = CW'(D_END);

    phase_e               r_phase;
    phase_e               w_phase_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [SH_W-1:0]      r_sh;
    logic [DATA_BITS-1:0] r_word;
    logic [DATA_BITS-1:0] w_word;
    logic                 r_cs_n;
    logic                 r_dout;
    logic                 w_cs_n_nxt;
    logic                 w_dout_nxt;
    logic                 w_last;
    logic                 w_halt;

    // The last data bit is taken straight from din so the word is whole
    // on the same edge that closes the frame.
    assign w_word = {r_word[DATA_BITS-2:0], i_din};
    assign w_last = (r_phase == PH_DATA) && (r_cnt == C_D_END);

`ifdef SFSM_HALT_EN
    assign w_halt = w_word[HALT_BIT];
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= PH_GAP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_dout  <= 1'b0;
            r_sh    <= '0;
            r_word  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_dout  <= w_dout_nxt;
            if (r_phase == PH_GAP) begin
                r_sh <= {P_CMD, i_addr};
            end else if (r_phase == PH_CMD || r_phase == PH_ADDR) begin
                r_sh <= r_sh << 1;
            end
            if (r_phase == PH_DATA) begin
                r_word <= w_word;
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_dout_nxt  = 1'b0;
        unique case (r_phase)
            PH_GAP: begin
                w_phase_nxt = PH_CMD;
                w_dout_nxt  = P_CMD[7];
            end
            PH_CMD: begin
                w_dout_nxt = r_sh[SH_W-2];
                if (r_cnt == C_CMD_END) begin
                    w_phase_nxt = PH_ADDR;
                end
            end
            PH_ADDR: begin
                if (r_cnt == C_A_END) begin
                    w_phase_nxt = PH_DATA;
                end else begin
                    w_dout_nxt = r_sh[SH_W-2];
                end
            end
            PH_DATA: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = w_halt ? PH_HALT : PH_GAP;
                end
            end
            PH_HALT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_phase_nxt = PH_GAP;
            end
        endcase
        w_cs_n_nxt = (w_phase_nxt == PH_GAP) || (w_phase_nxt == PH_HALT);
    end

    assign o_cs_n = r_cs_n;
    assign o_dout = r_dout;
    assign o_word = w_word;
    assign o_done = w_last;

endmodule

// File: rtl/sfsm_top.sv
// sfsm_top: table-driven FSM behind the 8-in/8-out pad wrapper; holds
// state and gpo registers. Optional halt on word[11] via SFSM_HALT_EN.
module sfsm_top #(
    parameter int         STATE_W   = 4,
    parameter logic [7:0] CMD_READ  = sfsm_pkg::CMD_READ,
    parameter int         ADDR_BITS = sfsm_pkg::ADDR_BITS
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    import sfsm_pkg::*;

    localparam int PAD = ADDR_BITS - STATE_W - 5;

    logic                 w_clk;
    logic                 w_rst;
    logic                 w_din;
    logic [4:0]           w_gpi;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_word;
    logic                 w_done;
    logic                 w_cs_n;
    logic                 w_dout;
    logic                 w_unused_bits;
    logic [STATE_W-1:0]   r_state;
    logic [GPO_MSB:0]     r_gpo;

    assign {w_gpi, w_din, w_rst, w_clk} = io_in;
    assign w_addr = {{PAD{1'b0}}, r_state, w_gpi};

    sfsm_spi_frame #(
        .P_CMD  (CMD_READ),
        .P_ADDR (ADDR_BITS)
    ) u_frame (
        .i_clk  (w_clk),
        .i_rst  (w_rst),
        .i_din  (w_din),
        .i_addr (w_addr),
        .o_cs_n (w_cs_n),
        .o_dout (w_dout),
        .o_word (w_word),
        .o_done (w_done)
    );

    // Halt and reserved bits are consumed inside the frame engine or not at all.
    assign w_unused_bits = ^w_word[NEXT_MSB-STATE_W:GPO_MSB+1];

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= '0;
            r_gpo   <= '0;
        end else if (w_done) begin
            r_state <= w_word[NEXT_MSB -: STATE_W];
            r_gpo   <= w_word[GPO_MSB:0];
        end
    end

    assign io_out = {r_gpo, w_dout, w_cs_n};

endmodule

// File: tb/tb_sfsm_top.sv
// tb_sfsm_top: random and directed frames against an SPI memory model;
// a scoreboard checks each frame's command, address, gpo and timing.
`timescale 1ns/1ps
module tb_sfsm_top;

`ifdef SFSM_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [5:0]  gpo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic [4:0] gpi = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {gpi, din, rst, clk};

    sfsm_top dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    wire       cs   = io_out[0];
    wire       dout = io_out[1];
    wire [5:0] gpo  = io_out[7:2];

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [15:0] mem [512];
    logic [3:0]  m_state = 4'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a < 16'd512) return mem[a[8:0]];
        return 16'hDEAD;
    endfunction

    // Serial memory: samples dout and drives din on the chip-clock falling
    // edge (its own rising SCK edge); garbage on din whenever not in data.
    initial begin : spi_mem
        int          mbits;
        logic [23:0] rx;
        logic [15:0] w;
        mbits = 0;
        rx    = '0;
        w     = '0;
        forever begin
            @(negedge clk);
            if (rst || cs) begin
                mbits = 0;
                din   = 1'($urandom);
            end else if (mbits < 24) begin
                rx    = {rx[22:0], dout};
                mbits++;
                din   = 1'($urandom);
                if (mbits == 24) w = mem_word(rx[15:0]);
            end else if (mbits < 40) begin
                din = w[39 - mbits];
                mbits++;
            end else begin
                din = 1'($urandom);
            end
        end
    end

    initial begin : monitor
        int          lo;
        int          hi;
        logic [23:0] rx;
        logic        nz;
        logic        moved;
        logic [5:0]  pg;
        exp_t        e;
        lo = 0; hi = 0; rx = '0; nz = 1'b0; moved = 1'b0; pg = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lo = 0; hi = 0; nz = 1'b0; moved = 1'b0;
            end else if (!cs) begin
                if (lo == 0) begin
                    check("gap_len", hi, 1);
                    rx = '0; nz = 1'b0; moved = 1'b0;
                end
                if (lo < 24) rx = {rx[22:0], dout};
                else if (dout !== 1'b0) nz = 1'b1;
                if (gpo !== pg) moved = 1'b1;
                lo++;
            end else begin
                if (lo != 0) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: actual addr %0h required none", rx[15:0]);
                    end else begin
                        e = sbq.pop_front();
                        check("cmd", rx[23:16], 8'h03);
                        check("addr", rx[15:0], e.addr);
                        check("gpo", gpo, e.gpo);
                        check("cs_low_len", lo, 40);
                        check("data_dout_zero", nz, 0);
                        check("gpo_stable", moved, 0);
                    end
                    lo = 0; hi = 0;
                end
                hi++;
            end
            pg = gpo;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the gap cycle: predicts the frame from the table.
    task automatic run_frame(input int chg_at, input logic [4:0] g_new);
        logic [15:0] a;
        logic [15:0] w;
        exp_t        e;
        a      = {7'd0, m_state, gpi};
        w      = mem_word(a);
        e.addr = a;
        e.gpo  = w[5:0];
        sbq.push_back(e);
        m_state = w[15:12];
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k == chg_at) gpi = g_new;
        end
    endtask

    task automatic do_reset(input int at_cnt, input logic [4:0] g_rel);
        for (int k = 1; k <= at_cnt; k++) tick();
        check("sb_empty_before_reset", sbq.size(), 0);
        rst = 1'b1;
        #1;
        check("rst_cs", cs, 1);
        check("rst_dout", dout, 0);
        check("rst_gpo", gpo, 0);
        sbq.delete();
        repeat (3) tick();
        gpi     = g_rel;
        m_state = 4'd0;
        rst     = 1'b0;
    endtask

    initial begin : driver
        int lows;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 16'($urandom);
            if (HALT_EN) mem[i][11] = 1'b0;
        end
        mem[9'h016] = 16'h5015;
        gpi = 5'b10110;

        repeat (3) tick();
        check("init_cs", cs, 1);
        check("init_dout", dout, 0);
        check("init_gpo", gpo, 0);
        rst = 1'b0;

        run_frame(5, 5'b10110);
        run_frame(5, 5'($urandom));
        for (int f = 0; f < 20; f++) begin
            run_frame(int'($urandom_range(1, 40)), 5'($urandom));
        end

        do_reset(15, 5'd0);
        mem[9'h000] = 16'h1001;
        mem[9'h020] = 16'h203F;
        run_frame(0, 5'd0);
        run_frame(0, 5'd0);
        run_frame(0, 5'd0);

        do_reset(2, 5'd0);
        mem[9'h000] = 16'h3812;
        run_frame(0, 5'd0);
`ifdef SFSM_HALT_EN
        lows = 0;
        repeat (200) begin
            tick();
            if (cs !== 1'b1 || dout !== 1'b0) lows++;
        end
        check("halt_cs_held", lows, 0);
        check("halt_gpo", gpo, 6'h12);
`else
        lows = 0;
        run_frame(0, 5'd0);
        run_frame(0, 5'd0);
`endif
        repeat (3) tick();
        check("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
